// File: rtl/reduce_monitor.sv
// Classifies the upstream AND/OR reduction into IDLE/PARTIAL/FULL, counts
// entries into FULL and activity starts, and offers snapshot reports over valid/ready.
module reduce_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             all_in,
  input  logic             any_in,
  input  logic             clr,
  input  logic             snap_req,
  input  logic             rpt_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] full_cnt,
  output logic [CNT_W-1:0] act_cnt,
  output logic             err,
  output logic             rpt_valid,
  output logic [CNT_W-1:0] rpt_full,
  output logic [CNT_W-1:0] rpt_act
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    PARTIAL = 2'b01,
    FULL    = 2'b10
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  cls_t             cur;
  cls_t             nxt;
  logic             illegal;
  logic             full_inc;
  logic             act_inc;
  logic             snap_acc;
  logic [CNT_W-1:0] full_nxt;
  logic [CNT_W-1:0] act_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= IDLE;
    else        cur <= nxt;
  end

  // An illegal AND-without-OR input holds the class, so no transition can count.
  always_comb begin
    nxt      = cur;
    illegal  = all_in & ~any_in;
    if (!illegal) begin
      if (any_in && all_in) nxt = FULL;
      else if (any_in)      nxt = PARTIAL;
      else                  nxt = IDLE;
    end
    full_inc = (nxt == FULL) && (cur != FULL);
    act_inc  = (cur == IDLE) && (nxt != IDLE);
    snap_acc = snap_req && !rpt_valid;

    full_nxt = snap_acc ? '0 : full_cnt;
    act_nxt  = snap_acc ? '0 : act_cnt;
    if (full_inc && full_nxt != CNT_MAX) full_nxt = full_nxt + CNT_ONE;
    if (act_inc && act_nxt != CNT_MAX)   act_nxt  = act_nxt + CNT_ONE;
    if (clr) begin
      full_nxt = '0;
      act_nxt  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_cnt <= '0;
      act_cnt  <= '0;
      err      <= 1'b0;
    end else begin
      full_cnt <= full_nxt;
      act_cnt  <= act_nxt;
      if (clr)          err <= 1'b0;
      else if (illegal) err <= 1'b1;
    end
  end

  // Report fields keep their last captured values after the consumer accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_full  <= '0;
      rpt_act   <= '0;
    end else if (snap_acc) begin
      rpt_valid <= 1'b1;
      rpt_full  <= full_cnt;
      rpt_act   <= act_cnt;
    end else if (rpt_valid && rpt_ready) begin
      rpt_valid <= 1'b0;
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_reduce_monitor.sv
// Directed bench for reduce_monitor: a vector table for the classification and
// snapshot flow, plus hand sequences for clr+snap, saturation and async reset.
module tb_reduce_monitor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       all_in = 1'b0, any_in = 1'b0, clr = 1'b0, snap_req = 1'b0, rpt_ready = 1'b0;
  logic [1:0] state;
  logic [7:0] full_cnt, act_cnt, rpt_full, rpt_act;
  logic       err, rpt_valid;

  logic       all4 = 1'b0, any4 = 1'b0;
  logic [1:0] state4;
  logic [3:0] full4, act4, rfull4, ract4;
  logic       err4, rv4;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic       any, all, clr, snap, ready;
    logic [1:0] st;
    logic [7:0] fc, ac;
    logic       er, rv;
    logic [7:0] rf, ra;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  reduce_monitor #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .all_in(all_in), .any_in(any_in), .clr(clr),
    .snap_req(snap_req), .rpt_ready(rpt_ready), .state(state),
    .full_cnt(full_cnt), .act_cnt(act_cnt), .err(err), .rpt_valid(rpt_valid),
    .rpt_full(rpt_full), .rpt_act(rpt_act)
  );

  reduce_monitor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .all_in(all4), .any_in(any4), .clr(1'b0),
    .snap_req(1'b0), .rpt_ready(1'b0), .state(state4),
    .full_cnt(full4), .act_cnt(act4), .err(err4), .rpt_valid(rv4),
    .rpt_full(rfull4), .rpt_act(ract4)
  );

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic a, input logic l, input logic c,
                                input logic s, input logic r);
    any_in = a; all_in = l; clr = c; snap_req = s; rpt_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input int fc, input int ac,
                           input logic er, input logic rv, input int rf, input int ra);
    check_output({tag, " state"}, int'(state), int'(st));
    check_output({tag, " full_cnt"}, int'(full_cnt), fc);
    check_output({tag, " act_cnt"}, int'(act_cnt), ac);
    check_output({tag, " err"}, int'(err), int'(er));
    check_output({tag, " rpt_valid"}, int'(rpt_valid), int'(rv));
    check_output({tag, " rpt_full"}, int'(rpt_full), rf);
    check_output({tag, " rpt_act"}, int'(rpt_act), ra);
  endtask

  task automatic add(input logic a, input logic l, input logic c, input logic s, input logic r,
                     input logic [1:0] st, input int fc, input int ac, input logic er,
                     input logic rv, input int rf, input int ra);
    vec_t v;
    v.any = a; v.all = l; v.clr = c; v.snap = s; v.ready = r;
    v.st = st; v.fc = 8'(fc); v.ac = 8'(ac); v.er = er; v.rv = rv;
    v.rf = 8'(rf); v.ra = 8'(ra);
    vq.push_back(v);
  endtask

  initial begin
    // any all clr snap ready | state full act err rv rf ra
    add(0,0,0,0,0, 2'b00, 0,0, 0, 0, 0,0);
    add(1,0,0,0,1, 2'b01, 0,1, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 1,1, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 1,1, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 1,1, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 2,2, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 2,2, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 2,2, 0, 0, 0,0);
    add(0,1,0,0,0, 2'b01, 2,2, 1, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 2,2, 1, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 2,2, 1, 0, 0,0);
    add(0,0,1,0,0, 2'b00, 0,0, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 0,1, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 0,1, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 0,2, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 0,2, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 1,3, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 1,3, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 2,4, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 2,4, 0, 0, 0,0);
    add(1,1,0,0,0, 2'b10, 3,4, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 3,4, 0, 0, 0,0);
    add(1,0,0,0,0, 2'b01, 3,5, 0, 0, 0,0);
    add(0,0,0,0,0, 2'b00, 3,5, 0, 0, 0,0);
    // snapshot coinciding with IDLE->FULL, then backpressure and an ignored snap
    add(1,1,0,1,0, 2'b10, 1,1, 0, 1, 3,5);
    add(1,1,0,0,0, 2'b10, 1,1, 0, 1, 3,5);
    add(1,1,0,0,0, 2'b10, 1,1, 0, 1, 3,5);
    add(1,1,0,0,0, 2'b10, 1,1, 0, 1, 3,5);
    add(1,1,0,1,0, 2'b10, 1,1, 0, 1, 3,5);
    add(1,1,0,0,1, 2'b10, 1,1, 0, 0, 3,5);

    #12;
    check_all("reset", 2'b00, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      apply_stimulus(vq[i].any, vq[i].all, vq[i].clr, vq[i].snap, vq[i].ready);
      check_all($sformatf("v%0d", i), vq[i].st, int'(vq[i].fc), int'(vq[i].ac),
                vq[i].er, vq[i].rv, int'(vq[i].rf), int'(vq[i].ra));
    end

    // build counters 7/9, set err, then clr and snap at the same edge
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(0,0,0,0,0);
      apply_stimulus(1,1,0,0,0);
    end
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0,0,0,0,0);
      apply_stimulus(1,0,0,0,0);
    end
    apply_stimulus(0,0,0,0,0);
    check_all("pre_clrsnap", 2'b00, 7, 9, 0, 0, 3, 5);
    apply_stimulus(0,1,0,0,0);
    check_output("illegal_idle err", int'(err), 1);
    apply_stimulus(0,0,1,1,0);
    check_all("clrsnap", 2'b00, 0, 0, 0, 1, 7, 9);
    apply_stimulus(0,0,0,0,1);
    check_output("clrsnap accept rpt_valid", int'(rpt_valid), 0);

    // saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      any4 = 1'b0; all4 = 1'b0;
      @(posedge clk); #1;
      any4 = 1'b1; all4 = 1'b1;
      @(posedge clk); #1;
      if (i == 14) begin
        check_output("sat15 full_cnt", int'(full4), 15);
        check_output("sat15 act_cnt", int'(act4), 15);
      end
    end
    check_output("sat20 full_cnt", int'(full4), 15);
    check_output("sat20 act_cnt", int'(act4), 15);
    check_output("sat20 state", int'(state4), 2);

    // pending report with nonzero counters, then asynchronous reset mid-cycle
    apply_stimulus(1,0,0,0,0);
    apply_stimulus(1,1,0,1,0);
    check_all("pre_rst", 2'b10, 1, 0, 0, 1, 0, 1);
    #3;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 2'b00, 0, 0, 0, 0, 0, 0);
    check_output("async_rst sat full_cnt", int'(full4), 0);
    @(posedge clk); #1;
    check_all("rst_held", 2'b00, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
